// File: rtl/pipe_stage_skid_pkg.sv
// Shared widths and field layout for the skid-buffered pipeline stage.
// Stage instances pack and unpack their bundles with these offsets.
package pipe_stage_skid_pkg;

    localparam int CTRL_W      = 10;
    localparam int DATA_W      = 70;
    localparam int STALL_CNT_W = 8;

    localparam int REGDST   = 0;
    localparam int ALUSRC   = 1;
    localparam int MEMTOREG = 2;
    localparam int REGWRITE = 3;
    localparam int MEMREAD  = 4;
    localparam int MEMWRITE = 5;
    localparam int BRANCH   = 6;
    localparam int ALUOP_LO = 7;
    localparam int ALUOP_HI = 8;
    localparam int SPARE    = 9;

    localparam int WORD_W  = 16;
    localparam int REG_W   = 3;
    localparam int IMM_OFS = 0;
    localparam int RD1_OFS = 16;
    localparam int RD2_OFS = 32;
    localparam int PC_OFS  = 48;
    localparam int RD_OFS  = 64;
    localparam int RT_OFS  = 67;

    function automatic logic [DATA_W-1:0] pack_data(
        input logic [WORD_W-1:0] imm,
        input logic [WORD_W-1:0] rd1,
        input logic [WORD_W-1:0] rd2,
        input logic [WORD_W-1:0] pc,
        input logic [REG_W-1:0]  rd,
        input logic [REG_W-1:0]  rt
    );
        logic [DATA_W-1:0] d;
        d = '0;
        d[IMM_OFS +: WORD_W] = imm;
        d[RD1_OFS +: WORD_W] = rd1;
        d[RD2_OFS +: WORD_W] = rd2;
        d[PC_OFS  +: WORD_W] = pc;
        d[RD_OFS  +: REG_W]  = rd;
        d[RT_OFS  +: REG_W]  = rt;
        return d;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One held pipeline entry: valid flag, control vector and payload.
// Data is kept when invalidated; only the control vector is cleared.
module pipe_entry
    import pipe_stage_skid_pkg::*;
#(
    parameter int CW = CTRL_W,
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          invalidate,
    input  logic          clear_ctrl,
    input  logic [CW-1:0] d_ctrl,
    input  logic [DW-1:0] d_data,
    output logic          valid,
    output logic [CW-1:0] ctrl,
    output logic [DW-1:0] data
);

    // Load wins over invalidate/clear; state moves on the falling edge
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= d_ctrl;
            data  <= d_data;
        end else begin
            if (invalidate) valid <= 1'b0;
            if (clear_ctrl) ctrl  <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage register with a 2-entry skid buffer, flush and stall counter.
// in_ready comes straight from the skid flag so back-pressure is registered.
module pipe_stage_skid #(
    parameter int CTRL_W      = pipe_stage_skid_pkg::CTRL_W,
    parameter int DATA_W      = pipe_stage_skid_pkg::DATA_W,
    parameter int STALL_CNT_W = pipe_stage_skid_pkg::STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    input  logic                   stall_clr
);

    logic              main_valid;
    logic              skid_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;

    logic              accept;
    logic              pop;
    logic              main_load;
    logic              main_inv;
    logic              main_clr;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_inv;
    logic              skid_clr;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;

    assign accept = in_valid & in_ready & ~flush;
    assign pop    = main_valid & out_ready;

    // Per-edge entry control: flush, fill, drain, skid capture
    always_comb begin
        main_load      = 1'b0;
        main_inv       = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_inv       = 1'b0;
        skid_clr       = 1'b0;
        priority case (1'b1)
            flush: begin
                main_inv = 1'b1;
                main_clr = 1'b1;
                skid_inv = 1'b1;
                skid_clr = 1'b1;
            end
            !main_valid: begin
                main_load = accept;
            end
            pop: begin
                skid_inv = 1'b1;
                skid_clr = 1'b1;
                if (accept) begin
                    main_load = 1'b1;
                end else if (skid_valid) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end else begin
                    main_inv = 1'b1;
                    main_clr = 1'b1;
                end
            end
            default: begin
                skid_load = accept;
            end
        endcase
    end

    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_d_data = main_from_skid ? skid_data : in_data;

    pipe_entry #(.CW(CTRL_W), .DW(DATA_W)) u_main (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (main_load),
        .invalidate (main_inv),
        .clear_ctrl (main_clr),
        .d_ctrl     (main_d_ctrl),
        .d_data     (main_d_data),
        .valid      (main_valid),
        .ctrl       (main_ctrl),
        .data       (main_data)
    );

    pipe_entry #(.CW(CTRL_W), .DW(DATA_W)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .invalidate (skid_inv),
        .clear_ctrl (skid_clr),
        .d_ctrl     (in_ctrl),
        .d_data     (in_data),
        .valid      (skid_valid),
        .ctrl       (skid_ctrl),
        .data       (skid_data)
    );

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    // Saturating count of edges where the head entry is held back
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready
                     && stall_cnt != {STALL_CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: driver pushes expected entries,
// a separate monitor pops and compares on each downstream handshake.
module tb_pipe_stage_skid;
    import pipe_stage_skid_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [CTRL_W-1:0]      in_ctrl;
    logic [DATA_W-1:0]      in_data;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [CTRL_W-1:0]      out_ctrl;
    logic [DATA_W-1:0]      out_data;
    logic [1:0]             occupancy;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   stall_clr;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } item_t;

    item_t sb[$];
    int    tests = 0;
    int    fails = 0;

    pipe_stage_skid dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    // Falling edges at 5, 15, ...; bench acts around rising edges
    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [79:0] act,
                         input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Offer one entry; push the expectation once it will be accepted
    task automatic send(input logic [CTRL_W-1:0] c,
                        input logic [DATA_W-1:0] d);
        item_t it;
        int n;
        @(posedge clk);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 required 1");
        end else begin
            it.c = c;
            it.d = d;
            sb.push_back(it);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        in_valid = 1'b0;
        in_ctrl  = '0;
        in_data  = '0;
        #1;
    endtask

    // Monitor: compare every downstream handshake against the queue
    initial begin
        item_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got data %0h required none",
                             out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_ctrl", 80'(out_ctrl), 80'(e.c));
                    check("out_data", 80'(out_data), 80'(e.d));
                end
            end else if (rst_n && !out_valid) begin
                check("bubble_ctrl", 80'(out_ctrl), 80'd0);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        stall_clr = 1'b0;
        #1;
        check("rst_in_ready", 80'(in_ready), 80'd1);
        check("rst_out_valid", 80'(out_valid), 80'd0);
        check("rst_occ", 80'(occupancy), 80'd0);
        check("rst_stall", 80'(stall_cnt), 80'd0);
        check("rst_ctrl", 80'(out_ctrl), 80'd0);
        check("rst_data", 80'(out_data), 80'd0);
        @(posedge clk);
        @(posedge clk);
        rst_n = 1'b1;

        // Single entry, one-edge latency
        out_ready = 1'b1;
        send(10'h2A5, 70'h1234);
        idle();
        check("t1_valid", 80'(out_valid), 80'd1);
        check("t1_ctrl", 80'(out_ctrl), 80'h2A5);
        check("t1_data", 80'(out_data), 80'h1234);
        check("t1_occ", 80'(occupancy), 80'd1);
        repeat (2) @(posedge clk);

        // Back-to-back stream with no back-pressure
        for (int i = 1; i <= 8; i++) begin
            send(CTRL_W'(i), DATA_W'(i));
            if (i > 1) check("t2_valid", 80'(out_valid), 80'd1);
        end
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("t2_stall", 80'(stall_cnt), 80'd0);
        check("t2_occ", 80'(occupancy), 80'd0);

        // Fill both entries, then drain in order
        out_ready = 1'b0;
        send(10'h3FF, pack_data(16'hAAAA, 16'h1, 16'h2, 16'h10, 3'd1, 3'd2));
        send(10'h0F0, pack_data(16'hBBBB, 16'h3, 16'h4, 16'h12, 3'd3, 3'd4));
        idle();
        check("t3_occ", 80'(occupancy), 80'd2);
        check("t3_in_ready", 80'(in_ready), 80'd0);
        check("t3_data_a", 80'(out_data),
              80'(pack_data(16'hAAAA, 16'h1, 16'h2, 16'h10, 3'd1, 3'd2)));
        check("t3_stall1", 80'(stall_cnt), 80'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t3_stall4", 80'(stall_cnt), 80'd4);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t3_in_ready_back", 80'(in_ready), 80'd1);
        check("t3_data_b", 80'(out_data),
              80'(pack_data(16'hBBBB, 16'h3, 16'h4, 16'h12, 3'd3, 3'd4)));
        check("t3_stall_hold", 80'(stall_cnt), 80'd4);
        repeat (2) @(posedge clk);

        // Flush with a full stage and a simultaneous offer
        out_ready = 1'b0;
        send(10'h111, 70'hD0D0);
        send(10'h222, 70'hE0E0);
        @(posedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 10'h333;
        in_data  = 70'hC0C0;
        @(posedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        in_ctrl  = '0;
        in_data  = '0;
        sb.delete();
        #1;
        check("t4_valid", 80'(out_valid), 80'd0);
        check("t4_ctrl", 80'(out_ctrl), 80'd0);
        check("t4_occ", 80'(occupancy), 80'd0);
        check("t4_in_ready", 80'(in_ready), 80'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t4_still_empty", 80'(out_valid), 80'd0);

        // Stall counter saturation and clear priority
        stall_clr = 1'b1;
        @(posedge clk);
        stall_clr = 1'b0;
        out_ready = 1'b0;
        send(10'h055, 70'hF00D);
        idle();
        repeat (300) @(posedge clk);
        #1;
        check("t5_sat", 80'(stall_cnt), 80'd255);
        stall_clr = 1'b1;
        @(posedge clk);
        stall_clr = 1'b0;
        #1;
        check("t5_clr", 80'(stall_cnt), 80'd0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Asynchronous reset while full
        out_ready = 1'b0;
        send(10'h0AA, 70'h6060);
        send(10'h155, 70'h7070);
        idle();
        check("t6_occ_pre", 80'(occupancy), 80'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", 80'(out_valid), 80'd0);
        check("t6_in_ready", 80'(in_ready), 80'd1);
        check("t6_occ", 80'(occupancy), 80'd0);
        check("t6_stall", 80'(stall_cnt), 80'd0);
        sb.delete();
        @(posedge clk);
        rst_n = 1'b1;

        // Recovery after reset
        out_ready = 1'b1;
        send(10'h1C3, 70'h3_0000_0000_0000_0001);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("end_sb_empty", 80'(sb.size()), 80'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control vector and a data payload between two pipeline stages using a valid/ready handshake.
- Contains a 2-entry skid buffer, so `in_ready` is registered and back-pressure does not form a combinational path through the stage.
- Adds flush (bubble insertion), control zeroing on bubbles, and a saturating stall counter for performance debug.

Parameters:
- CTRL_W, 10, width of control vector (regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, branch, aluOp[1:0], spare); zeroed on any bubble.
- DATA_W, 70, width of data payload (imm, rd1, rd2, pc+2 at 16 bits each, plus rd and rt at 3 bits each); never zeroed.
- STALL_CNT_W, 8, width of the saturating stall counter.

Ports:
- clk  in  1  stage clock; all state updates on the falling edge, consistent with the rest of the pipeline.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has a valid instruction.
- in_ready  out  1  stage can accept; registered.
- in_ctrl  in  CTRL_W  upstream control vector.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  discard all held entries (branch taken / hazard squash).
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control vector; all-zero whenever out_valid=0.
- out_data  out  DATA_W  payload of head entry; holds its last value when empty.
- occupancy  out  2  number of held entries, 0..2.
- stall_cnt  out  STALL_CNT_W  count of edges with out_valid=1 and out_ready=0; saturates at all-ones.
- stall_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
Reset (async, rst_n=0):
- main and skid entries invalid; all ctrl storage 0; data storage 0.
- in_ready=1, out_valid=0, occupancy=0, stall_cnt=0.
- Deassertion is sampled at the next falling edge.

Storage and handshake:
- Two entries: main (head, drives out_*) and skid.
- Accept occurs on a falling edge when in_valid & in_ready. Pop occurs on a falling edge when out_valid & out_ready.
- in_ready = !skid_valid, registered.

Per-edge rules, applied in priority order:
1. flush=1:
   - Both entries become invalid and their ctrl is zeroed.
   - Input is not accepted even if in_valid & in_ready; upstream must also be squashed.
   - in_ready=1 next cycle.
2. Main empty, accept: main <= input.
3. Main full, pop, no accept: main <= skid if skid is valid, else main becomes invalid; skid becomes invalid.
4. Main full, pop, accept: this can only happen with the skid empty. main <= input.
5. Main full, no pop, accept: skid <= input; in_ready drops on the same edge.
6. Main full, no pop, no accept: hold.

Ordering and latency:
- Entries leave in strict arrival order. No entry is duplicated or dropped except by flush.
- Latency from input to out_valid is one falling edge when the stage is empty.
- Throughput is one entry per cycle while out_ready stays high.
- Bubble output: out_ctrl is forced to 0 when out_valid=0, so regWrite and memWrite are never asserted by an empty stage.

occupancy:
- Equals main_valid + skid_valid, registered.

stall_cnt:
- Increments on each edge with out_valid=1 and out_ready=0; saturates at all-ones.
- stall_clr has priority over increment.
- flush does not clear stall_cnt.
- Reset clears stall_cnt.

Reset mid-operation:
- Held entries are lost immediately and outputs go to their reset values asynchronously.

Decomposition:
- Shared package: CTRL_W and the bit indices of each control field (REGDST, ALUSRC, MEMTOREG, REGWRITE, MEMREAD, MEMWRITE, BRANCH, ALUOP_LO, ALUOP_HI).
- Shared package: DATA_W and the field offsets of imm, rd1, rd2, pc, rd and rt. Stage instances pack and unpack with these.
- One sub-module, pipe_entry: a single valid+ctrl+data register with load, clear_ctrl and invalidate controls. It is instantiated twice, as main and skid.

Test Plan:
1. Reset, then in_valid=1 with in_ctrl=10'h2A5, in_data=70'h1234, out_ready=1 -> after one falling edge: out_valid=1, out_ctrl=10'h2A5, out_data=70'h1234, occupancy=1.
2. Stream of 8 entries (data 1..8), out_ready=1 throughout -> outputs 1..8 on consecutive cycles, in_ready stays 1, stall_cnt=0.
3. Push A then B with out_ready=0 -> occupancy=2, in_ready=0, out_data=A. Raise out_ready -> A, then B, both in order; in_ready returns to 1 after the first pop; stall_cnt equals the number of held edges.
4. occupancy=2, then flush=1 with in_valid=1 (data C) -> next cycle: out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, and C never appears at the output.
5. Hold out_ready=0 with main valid for 300 edges and STALL_CNT_W=8 -> stall_cnt=255. Pulse stall_clr together with a stall -> stall_cnt=0.
6. Assert rst_n=0 asynchronously between edges while occupancy=2 -> out_valid=0, in_ready=1, occupancy=0, all without waiting for a clock edge.
